// File: rtl/hci_core_id_responder_pkg.sv
// Shared definitions for the HCI ID responder slice.
// hci_size_parameter_t is the HCI size record carried by every HCI port;
// id_resp_entry_width() gives the width of one buffered response entry
// {r_data, r_opc, r_user, r_ecc, id}.
package hci_core_id_responder_pkg;

    typedef struct packed {
        int unsigned DW;
        int unsigned AW;
        int unsigned BW;
        int unsigned UW;
        int unsigned IW;
        int unsigned EW;
        int unsigned EHW;
    } hci_size_parameter_t;

    localparam hci_size_parameter_t HCI_SIZE_DEFAULT =
        '{DW: 32, AW: 32, BW: 4, UW: 1, IW: 1, EW: 1, EHW: 1};

    function automatic int unsigned id_resp_entry_width(input hci_size_parameter_t s);
        return s.DW + s.UW + s.EW + s.IW + 1;
    endfunction

endpackage

// File: rtl/hci_core_intf.sv
// HCI core interface: request channel (req/gnt/add/wen/data/be/user/id/ecc),
// response channel (r_valid/r_ready/r_data/r_opc/r_user/r_id/r_ecc) and the
// EHW-wide early/handshake replicas (ereq/egnt/r_evalid/r_eready).
// initiator drives requests, target drives grants and responses.
interface hci_core_intf
    import hci_core_id_responder_pkg::*;
#(
    parameter hci_size_parameter_t HCI_SIZE = HCI_SIZE_DEFAULT
) ();
    localparam int unsigned DW  = HCI_SIZE.DW;
    localparam int unsigned AW  = HCI_SIZE.AW;
    localparam int unsigned BW  = HCI_SIZE.BW;
    localparam int unsigned UW  = HCI_SIZE.UW;
    localparam int unsigned IW  = HCI_SIZE.IW;
    localparam int unsigned EW  = HCI_SIZE.EW;
    localparam int unsigned EHW = HCI_SIZE.EHW;

    logic           req;
    logic           gnt;
    logic [AW-1:0]  add;
    logic           wen;
    logic [DW-1:0]  data;
    logic [BW-1:0]  be;
    logic           r_ready;
    logic [UW-1:0]  user;
    logic [IW-1:0]  id;
    logic [DW-1:0]  r_data;
    logic           r_valid;
    logic           r_opc;
    logic [UW-1:0]  r_user;
    logic [IW-1:0]  r_id;
    logic [EW-1:0]  ecc;
    logic [EW-1:0]  r_ecc;
    logic [EHW-1:0] ereq;
    logic [EHW-1:0] egnt;
    logic [EHW-1:0] r_eready;
    logic [EHW-1:0] r_evalid;

    modport initiator (
        output req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
        input  gnt, r_data, r_valid, r_opc, r_user, r_id, r_ecc, egnt, r_evalid
    );

    modport target (
        input  req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
        output gnt, r_data, r_valid, r_opc, r_user, r_id, r_ecc, egnt, r_evalid
    );

endinterface

// File: rtl/hci_core_id_resp_fifo.sv
// Response FIFO for the ID responder.
// Ports: clk_i/rst_ni (async active-low), clear_i (sync flush),
//        push_i/data_i (write), pop_i/data_o (read, head shown combinationally),
//        full_o/empty_o status.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module hci_core_id_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    used_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (used_q == '0);
    assign full_o  = (used_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot this cycle, so a push into a full FIFO is fine then.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            used_q <= '0;
        end else if (clear_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            used_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            used_q <= used_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/hci_core_id_responder.sv
// Adds ID-tagged, flow-controlled responses in front of a fixed-latency
// memory. Requests pass straight through while credit remains; the ID of
// each granted request is held for the single-cycle memory latency and then
// stored with the response in a FIFO that the upstream drains at its pace.
// Ports: clk_i, rst_ni (async active-low), clear_i (sync flush),
//        in  (target, upstream OoO mux), out (initiator, memory),
//        outstanding_o (credit counter), protocol_err_o (sticky stray response).
module hci_core_id_responder
    import hci_core_id_responder_pkg::*;
#(
    parameter int unsigned         DEPTH       = 4,
    parameter hci_size_parameter_t HCI_SIZE_in = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    hci_core_intf.target                 in,
    hci_core_intf.initiator              out,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic                         protocol_err_o
);
    localparam int unsigned IW     = HCI_SIZE_in.IW;
    localparam int unsigned EHW    = HCI_SIZE_in.EHW;
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned ENTRYW = id_resp_entry_width(HCI_SIZE_in);

    logic [CW-1:0]     cnt_q;
    logic              pending_q;
    logic [IW-1:0]     pend_id_q;
    logic              err_q;
    logic              clr_q;

    logic              credit, out_req, hs, pop, push, stray;
    logic              fifo_full, fifo_empty, in_rvalid;
    logic [ENTRYW-1:0] fifo_wdata, fifo_rdata;

    // Counter covers in-flight plus buffered, so credit alone bounds the FIFO.
    assign credit  = (cnt_q < CW'(DEPTH));
    assign out_req = in.req & credit;
    assign hs      = out_req & out.gnt;

    assign out.req     = out_req;
    assign in.gnt      = out.gnt & credit;
    assign out.add     = in.add;
    assign out.wen     = in.wen;
    assign out.data    = in.data;
    assign out.be      = in.be;
    assign out.user    = in.user;
    assign out.ecc     = in.ecc;
    assign out.id      = in.id;
    assign out.r_ready = 1'b1;

    assign push  = out.r_valid & pending_q;
    // The response to a request granted during a flush lands one cycle later;
    // it is dropped silently rather than flagged.
    assign stray = out.r_valid & ~pending_q & ~clr_q;

    assign in_rvalid = ~fifo_empty;
    assign pop       = in_rvalid & in.r_ready;

    assign fifo_wdata = {out.r_data, out.r_opc, out.r_user, out.r_ecc, pend_id_q};
    assign {in.r_data, in.r_opc, in.r_user, in.r_ecc, in.r_id} = fifo_rdata;
    assign in.r_valid = in_rvalid;

    hci_core_id_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRYW)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            pend_id_q <= '0;
            err_q     <= 1'b0;
            clr_q     <= 1'b0;
        end else if (clear_i) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            clr_q     <= 1'b1;
        end else begin
            clr_q     <= 1'b0;
            cnt_q     <= cnt_q + CW'(hs) - CW'(pop);
            // Memory answers exactly one cycle later, so only the last grant matters.
            pending_q <= hs;
            if (hs)    pend_id_q <= in.id;
            if (stray) err_q     <= 1'b1;
        end
    end

    assign outstanding_o  = cnt_q;
    assign protocol_err_o = err_q;

    generate
        if (EHW > 0) begin : g_ehw
            assign in.egnt      = {EHW{out.gnt}};
            assign in.r_evalid  = {EHW{in_rvalid}};
            assign out.ereq     = {EHW{out_req}};
            assign out.r_eready = '1;
        end else begin : g_no_ehw
            assign in.egnt      = '1;
            assign in.r_evalid  = '0;
            assign out.ereq     = '0;
            assign out.r_eready = '1;
        end
    endgenerate

    // Credit accounting must keep the FIFO from overflowing.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_hci_core_id_responder.sv
module tb_hci_core_id_responder;
    import hci_core_id_responder_pkg::*;

    localparam int unsigned DEPTH = 3;
    localparam hci_size_parameter_t SZ =
        '{DW: 32, AW: 32, BW: 4, UW: 2, IW: 2, EW: 1, EHW: 1};

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       clear_i = 1'b0;
    logic [1:0] outstanding_o;
    logic       protocol_err_o;

    hci_core_intf #(.HCI_SIZE(SZ)) in_if ();
    hci_core_intf #(.HCI_SIZE(SZ)) out_if ();

    hci_core_id_responder #(
        .DEPTH       (DEPTH),
        .HCI_SIZE_in (SZ)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .in             (in_if),
        .out            (out_if),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        logic        opc;
        logic [1:0]  u;
        logic        e;
        logic [1:0]  id;
    } rsp_t;

    // Reference model: requests accepted by memory and not yet answered,
    // responses waiting for upstream, and the outstanding tally.
    rsp_t       exp_q[$];
    logic [1:0] infl_q[$];
    int         m_cnt = 0;
    bit         m_err = 0;
    bit         m_drop = 0;

    int n_chk = 0, n_fail = 0;
    int dut_gnt = 0, dut_max = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        in_if.req = 0; in_if.id = 0; in_if.add = 0; in_if.wen = 1; in_if.data = 0;
        in_if.be = 0; in_if.user = 0; in_if.ecc = 0; in_if.r_ready = 1;
        in_if.ereq = 0; in_if.r_eready = 1;
        out_if.gnt = 0; out_if.egnt = 0; out_if.r_evalid = 0; out_if.r_id = 0;
    endtask

    task automatic flush_model();
        exp_q.delete(); infl_q.delete(); m_cnt = 0; m_err = 0;
    endtask

    // One clock: check at negedge, advance model, drive memory after posedge.
    task automatic step();
        bit   cr, hs, pop;
        rsp_t r;
        @(negedge clk_i);
        cr = (m_cnt < DEPTH);
        chk("out_req", out_if.req, in_if.req & cr);
        chk("in_gnt", in_if.gnt, out_if.gnt & cr);
        chk("ereq", out_if.ereq, in_if.req & cr);
        chk("egnt", in_if.egnt, out_if.gnt);
        chk("r_valid", in_if.r_valid, exp_q.size() > 0);
        chk("r_evalid", in_if.r_evalid, exp_q.size() > 0);
        chk("mem_ready", {out_if.r_ready, out_if.r_eready}, 2'b11);
        chk("outstanding", outstanding_o, m_cnt);
        chk("proto_err", protocol_err_o, m_err);
        chk("pass_ctl", {out_if.add, out_if.id, out_if.wen, out_if.be, out_if.user, out_if.ecc},
                        {in_if.add, in_if.id, in_if.wen, in_if.be, in_if.user, in_if.ecc});
        chk("pass_data", out_if.data, in_if.data);
        if (exp_q.size() > 0) begin
            r = exp_q[0];
            chk("head", {in_if.r_data, in_if.r_opc, in_if.r_user, in_if.r_ecc, in_if.r_id},
                        {r.d, r.opc, r.u, r.e, r.id});
        end
        if (in_if.gnt === 1'b1 && in_if.req === 1'b1) dut_gnt++;
        if (int'(outstanding_o) > dut_max) dut_max = int'(outstanding_o);

        hs  = in_if.req & out_if.gnt & cr;
        pop = (exp_q.size() > 0) && in_if.r_ready;
        if (clear_i) begin
            flush_model();
            m_drop = 1;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (out_if.r_valid && !m_drop) begin
                if (infl_q.size() > 0) begin
                    r.d = out_if.r_data; r.opc = out_if.r_opc; r.u = out_if.r_user;
                    r.e = out_if.r_ecc; r.id = infl_q.pop_front();
                    exp_q.push_back(r);
                end else begin
                    m_err = 1;
                end
            end
            if (hs) infl_q.push_back(in_if.id);
            m_cnt += int'(hs) - int'(pop);
            m_drop = 0;
        end

        @(posedge clk_i); #1;
        out_if.r_valid = hs;
        out_if.r_data  = $urandom();
        out_if.r_opc   = 1'($urandom());
        out_if.r_user  = 2'($urandom());
        out_if.r_ecc   = 1'($urandom());
    endtask

    task automatic do_reset();
        #2 rst_ni = 0;
        #1;
        in_if.req = 1;
        #1;
        chk("rst_rvalid", in_if.r_valid, 0);
        chk("rst_outst", outstanding_o, 0);
        chk("rst_err", protocol_err_o, 0);
        chk("rst_req_pass", out_if.req, 1);
        in_if.req = 0;
        out_if.r_valid = 0;
        flush_model();
        m_drop = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        idle();
        out_if.r_valid = 0; out_if.r_data = 0; out_if.r_opc = 0;
        out_if.r_user = 0; out_if.r_ecc = 0;
        @(posedge clk_i); #1;
        do_reset();

        // single read: id 2, addr 0x40, memory returns 0xCAFE
        in_if.req = 1; in_if.id = 2; in_if.add = 32'h40; in_if.wen = 1; out_if.gnt = 1;
        in_if.r_ready = 0;
        step();
        chk("sr_outst", outstanding_o, 1);
        in_if.req = 0; out_if.r_data = 32'hCAFE;
        step();
        chk("sr_rvalid", in_if.r_valid, 1);
        chk("sr_rid", in_if.r_id, 2);
        chk("sr_rdata", in_if.r_data, 32'hCAFE);
        in_if.r_ready = 1;
        step();
        chk("sr_drained", outstanding_o, 0);

        // backpressure: upstream not ready, continuous requests
        dut_gnt = 0; in_if.req = 1; out_if.gnt = 1; in_if.r_ready = 0;
        for (int i = 0; i < 8; i++) begin
            in_if.id = 2'(dut_gnt % 2);
            step();
        end
        chk("bp_grants", dut_gnt, 3);
        chk("bp_outst", outstanding_o, 3);
        chk("bp_gnt_low", in_if.gnt, 0);
        in_if.req = 0; in_if.r_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rvalid", in_if.r_valid, 1);
            chk("bp_order", in_if.r_id, 2'(i % 2));
            step();
        end
        chk("bp_empty", outstanding_o, 0);

        // throughput: 20 back-to-back requests
        dut_gnt = 0; dut_max = 0; in_if.req = 1; out_if.gnt = 1; in_if.r_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_if.id = 2'($urandom()); in_if.add = $urandom(); in_if.data = $urandom();
            step();
        end
        chk("tp_grants", dut_gnt, 20);
        chk("tp_max_le2", dut_max <= 2, 1);
        in_if.req = 0;
        repeat (3) step();

        // stray memory response with nothing pending
        out_if.r_valid = 1;
        step();
        chk("err_set", protocol_err_o, 1);
        chk("err_no_push", in_if.r_valid, 0);
        step();
        chk("err_sticky", protocol_err_o, 1);
        clear_i = 1; step(); clear_i = 0;
        chk("err_clear", protocol_err_o, 0);
        step();

        // clear with 2 buffered and one response on the wire
        in_if.req = 1; out_if.gnt = 1; in_if.r_ready = 0;
        repeat (3) step();
        in_if.req = 0;
        chk("cl_pre_outst", outstanding_o, 3);
        chk("cl_pre_rvalid", in_if.r_valid, 1);
        clear_i = 1; step(); clear_i = 0;
        chk("cl_outst", outstanding_o, 0);
        chk("cl_rvalid", in_if.r_valid, 0);
        out_if.r_valid = 1;   // late response right after the flush
        in_if.r_ready = 1;
        step();
        chk("cl_late_err", protocol_err_o, 0);
        chk("cl_late_rvalid", in_if.r_valid, 0);
        step();

        // async reset with two entries buffered
        in_if.req = 1; out_if.gnt = 1; in_if.r_ready = 0;
        repeat (3) step();
        in_if.req = 0;
        chk("rs_pre_rvalid", in_if.r_valid, 1);
        do_reset();
        in_if.r_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("rs_no_rvalid", in_if.r_valid, 0);
            step();
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_if.req     = ($urandom_range(99) < 70);
            in_if.id      = 2'($urandom());
            in_if.add     = $urandom();
            in_if.wen     = 1'($urandom());
            in_if.data    = $urandom();
            in_if.be      = 4'($urandom());
            in_if.user    = 2'($urandom());
            in_if.ecc     = 1'($urandom());
            out_if.gnt    = ($urandom_range(99) < 80);
            in_if.r_ready = ($urandom_range(99) < 60);
            clear_i       = ($urandom_range(99) == 0);
            if (!out_if.r_valid && $urandom_range(99) < 3) out_if.r_valid = 1;
            step();
        end
        clear_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
